// File: rtl/rhythm_step_sequencer.sv
// Step sequencer driven by the divided tick clock: detects tick rising edges,
// walks a programmable on/off pattern and produces beat, bar, note-on and gate outputs.
module rhythm_step_sequencer #(
    parameter int STEPS    = 16,
    parameter int IDX_W    = 4,
    parameter int GATE_LEN = 8,
    parameter int GATE_W   = 8
) (
    input  logic             reference_clk,
    input  logic             reset,
    input  logic             clk_div,
    input  logic             run,
    input  logic             load,
    input  logic [STEPS-1:0] pattern,
    output logic [IDX_W-1:0] step_idx,
    output logic             beat,
    output logic             bar_start,
    output logic             note_on,
    output logic             gate,
    output logic             playing
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]  LAST_STEP = IDX_W'(STEPS - 1);
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_LEN);

    state_t state_reg;
    state_t state_next;

    logic             clk_div_s_reg;
    logic             clk_div_q_reg;
    logic [1:0]       prime_reg;
    logic             tick;

    logic [STEPS-1:0] pending_reg;
    logic [STEPS-1:0] active_reg;
    logic [STEPS-1:0] active_next;
    logic [STEPS-1:0] next_pat;

    logic [IDX_W-1:0] step_idx_reg;
    logic [IDX_W-1:0] step_idx_next;
    logic [IDX_W-1:0] step_inc;
    logic             wrap;
    logic [STEPS-1:0] step_sel;
    logic             active_bit;

    logic             beat_reg;
    logic             beat_next;
    logic             bar_start_reg;
    logic             bar_start_next;
    logic             note_on_reg;
    logic             note_on_next;
    logic [GATE_W-1:0] gate_cnt_reg;
    logic [GATE_W-1:0] gate_cnt_next;
    logic             gate_reg;
    logic             gate_next;
    logic             playing_reg;
    logic             playing_next;

    // clk_div is sampled once before edge detection; prime_reg masks the false
    // edge that the cleared sample registers would otherwise show after reset.
    always_ff @(posedge reference_clk or posedge reset) begin
        if (reset) begin
            clk_div_s_reg <= 1'b0;
            clk_div_q_reg <= 1'b0;
            prime_reg     <= 2'b00;
        end else begin
            clk_div_s_reg <= clk_div;
            clk_div_q_reg <= clk_div_s_reg;
            prime_reg     <= {prime_reg[0], 1'b1};
        end
    end

    assign tick     = clk_div_s_reg & ~clk_div_q_reg & prime_reg[1];
    assign next_pat = load ? pattern : pending_reg;

    assign wrap     = (step_idx_reg == LAST_STEP);
    assign step_inc = wrap ? '0 : step_idx_reg + IDX_W'(1);

    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_step_sel
            assign step_sel[gi] = active_reg[gi] && (step_inc == IDX_W'(gi));
        end
    endgenerate

    assign active_bit = |step_sel;

    always_ff @(posedge reference_clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!run) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_ARMED;
                ST_ARMED: if (tick) state_next = ST_RUN;
                ST_RUN:   state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        step_idx_next  = step_idx_reg;
        beat_next      = 1'b0;
        bar_start_next = 1'b0;
        note_on_next   = 1'b0;
        active_next    = active_reg;
        gate_cnt_next  = gate_cnt_reg;

        if (state_reg == ST_IDLE) begin
            active_next = next_pat;
        end

        if (!run) begin
            step_idx_next = '0;
        end else begin
            case (state_reg)
                ST_ARMED: begin
                    if (tick) begin
                        step_idx_next  = '0;
                        beat_next      = 1'b1;
                        bar_start_next = 1'b1;
                        note_on_next   = next_pat[0];
                        active_next    = next_pat;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        beat_next     = 1'b1;
                        step_idx_next = step_inc;
                        // A newly loaded pattern only takes effect on entry to step 0.
                        if (wrap) begin
                            bar_start_next = 1'b1;
                            note_on_next   = next_pat[0];
                            active_next    = next_pat;
                        end else begin
                            note_on_next = active_bit;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (!run) begin
            gate_cnt_next = '0;
        end else if (note_on_next) begin
            gate_cnt_next = GATE_LOAD;
        end else if (gate_cnt_reg != '0) begin
            gate_cnt_next = gate_cnt_reg - GATE_W'(1);
        end

        gate_next    = (gate_cnt_next != '0);
        playing_next = (state_next == ST_RUN);
    end

    always_ff @(posedge reference_clk or posedge reset) begin
        if (reset) begin
            pending_reg   <= '0;
            active_reg    <= '0;
            step_idx_reg  <= '0;
            beat_reg      <= 1'b0;
            bar_start_reg <= 1'b0;
            note_on_reg   <= 1'b0;
            gate_cnt_reg  <= '0;
            gate_reg      <= 1'b0;
            playing_reg   <= 1'b0;
        end else begin
            if (load) begin
                pending_reg <= pattern;
            end
            active_reg    <= active_next;
            step_idx_reg  <= step_idx_next;
            beat_reg      <= beat_next;
            bar_start_reg <= bar_start_next;
            note_on_reg   <= note_on_next;
            gate_cnt_reg  <= gate_cnt_next;
            gate_reg      <= gate_next;
            playing_reg   <= playing_next;
        end
    end

    assign step_idx  = step_idx_reg;
    assign beat      = beat_reg;
    assign bar_start = bar_start_reg;
    assign note_on   = note_on_reg;
    assign gate      = gate_reg;
    assign playing   = playing_reg;

endmodule
